// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

   localparam int ADDR_W = 7;
   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_e;

   // A count byte of zero stands for a full 128-byte image.
   function automatic logic [BYTE_W-1:0] frame_len(input logic [BYTE_W-1:0] count);
      return (count == '0) ? 8'd128 : count;
   endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit recheck, mid-bit sampling.
module uart_rx
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   output logic              frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic              rx_meta_q, rx_sync_q, rx_prev_q;
   logic              busy_q;
   logic [3:0]        bit_idx_q;
   logic [CW-1:0]     cnt_q;
   logic [BYTE_W-1:0] shift_q, byte_q;
   logic              valid_q, ferr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         busy_q    <= 1'b0;
         bit_idx_q <= '0;
         cnt_q     <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         if (!busy_q) begin
            if (rx_prev_q && !rx_sync_q) begin
               busy_q    <= 1'b1;
               cnt_q     <= '0;
               bit_idx_q <= '0;
            end
         // Bit 0 is the start bit, sampled after half a period; 9 is the stop bit.
         end else if (cnt_q == ((bit_idx_q == 4'd0) ? HALF_M1 : FULL_M1)) begin
            cnt_q <= '0;
            if (bit_idx_q == 4'd0) begin
               if (rx_sync_q) busy_q <= 1'b0;
               else           bit_idx_q <= 4'd1;
            end else if (bit_idx_q == 4'd9) begin
               busy_q <= 1'b0;
               if (rx_sync_q) begin
                  byte_q  <= shift_q;
                  valid_q <= 1'b1;
               end else begin
                  ferr_q <= 1'b1;
               end
            end else begin
               shift_q   <= {rx_sync_q, shift_q[BYTE_W-1:1]};
               bit_idx_q <= bit_idx_q + 4'd1;
            end
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a framed UART image into instruction RAM and holds the core in reset until done.
// Optional XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                CLKS_PER_BIT = 104,
   parameter logic [BYTE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic [ADDR_W-1:0] inst_address,
   output logic [BYTE_W-1:0] inst_data,
   output logic              inst_we,
   output logic              core_rst_n,
   output logic              load_done,
   output logic              load_err,
   output state_e            state_dbg
);

   logic [BYTE_W-1:0] rx_byte;
   logic              rx_valid, rx_ferr;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .byte_out   (rx_byte),
      .byte_valid (rx_valid),
      .frame_err  (rx_ferr)
   );

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BYTE_W-1:0] data_q, data_d;
   logic [BYTE_W-1:0] remain_q, remain_d;
   logic              we_q, we_d;
   logic              crst_q, crst_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_q, csum_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         remain_q <= '0;
         we_q     <= 1'b0;
         crst_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         remain_q <= remain_d;
         we_q     <= we_d;
         crst_q   <= crst_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      // The address steps once the write strobe has been seen by the RAM.
      addr_d   = we_q ? addr_q + ADDR_W'(1) : addr_q;
      data_d   = data_q;
      remain_d = remain_q;
      we_d     = 1'b0;
      crst_d   = crst_q;
      done_d   = done_q;
      err_d    = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rx_valid && rx_byte == SYNC_BYTE) state_d = ST_COUNT;
         end
         ST_COUNT: begin
            if (rx_ferr) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else if (rx_valid) begin
               remain_d = frame_len(rx_byte);
               addr_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_d   = '0;
`endif
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_ferr) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else if (rx_valid) begin
               we_d     = 1'b1;
               data_d   = rx_byte;
               remain_d = remain_q - 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
               csum_d   = csum_q ^ rx_byte;
               if (remain_q == 8'd1) state_d = ST_CHECK;
`else
               if (remain_q == 8'd1) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  crst_d  = 1'b1;
               end
`endif
            end
         end
         ST_CHECK: begin
            if (rx_ferr) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            end else if (rx_valid) begin
               if (rx_byte == csum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  crst_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
`endif
            end
         end
         ST_DONE, ST_ERR: begin
            if (rx_valid && rx_byte == SYNC_BYTE) begin
               state_d = ST_COUNT;
               done_d  = 1'b0;
               err_d   = 1'b0;
               crst_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign inst_address = addr_q;
   assign inst_data    = data_q;
   assign inst_we      = we_q;
   assign core_rst_n   = crst_q;
   assign load_done    = done_q;
   assign load_err     = err_q;
   assign state_dbg    = state_q;

endmodule
